// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, the load/store port and the memory-controller bus of mem_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the memory controller.
interface mem_arbiter_if;
  logic [31:0] if_addr;
  logic        if_req;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_err;

  logic [31:0] d_addr;
  logic        d_read_valid;
  logic        d_write_valid;
  logic [31:0] d_wdata;
  logic [1:0]  d_width;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_err;

  logic [31:0] mem_addr;
  logic        mem_read_valid;
  logic        mem_write_valid;
  logic [31:0] mem_write_data;
  logic [1:0]  mem_width;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  modport slave (
    input  if_addr, if_req, d_addr, d_read_valid, d_write_valid, d_wdata, d_width,
           mem_read_data, mem_ready,
    output if_rdata, if_ready, if_err, d_rdata, d_ready, d_err,
           mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width
  );

  modport master (
    output if_addr, if_req, d_addr, d_read_valid, d_write_valid, d_wdata, d_width,
           mem_read_data, mem_ready,
    input  if_rdata, if_ready, if_err, d_rdata, d_ready, d_err,
           mem_addr, mem_read_valid, mem_write_valid, mem_write_data, mem_width
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter driving a registered request onto the memory bus.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [1:0]       mem_width_q, mem_width_d;
  logic             mem_rv_q, mem_rv_d;
  logic             mem_wv_q, mem_wv_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      d_rdata_q, d_rdata_d;
  logic             if_ready_q, if_ready_d, if_err_q, if_err_d;
  logic             d_ready_q, d_ready_d, d_err_q, d_err_d;

  logic if_pend, d_pend, any_pend, grant_d, timed_out, done;

  assign if_pend   = bus.if_req;
  assign d_pend    = bus.d_read_valid | bus.d_write_valid;
  assign any_pend  = if_pend | d_pend;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign done      = bus.mem_ready | timed_out;

`ifdef MEM_ARB_RR_EN
  // Set when the most recent grant went to the data port; a tie goes to the other port.
  logic last_d_q;
  assign grant_d = d_pend & (~if_pend | ~last_d_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_d_q <= 1'b0;
    end else if (state_q == IDLE && any_pend) begin
      last_d_q <= grant_d;
    end
  end
`else
  assign grant_d = d_pend;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pend) state_d = BUSY;
      BUSY:    if (done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_width_d = mem_width_q;
    mem_rv_d    = mem_rv_q;
    mem_wv_d    = mem_wv_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    if_err_d    = 1'b0;
    d_ready_d   = 1'b0;
    d_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_pend) begin
          owner_d = grant_d;
          cnt_d   = '0;
          if (grant_d) begin
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            mem_width_d = bus.d_width;
            mem_rv_d    = bus.d_read_valid;
            mem_wv_d    = ~bus.d_read_valid;
          end else begin
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_width_d = 2'd2;
            mem_rv_d    = 1'b1;
            mem_wv_d    = 1'b0;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // mem_ready takes precedence over an expiring timeout in the same cycle
        if (done) begin
          mem_rv_d = 1'b0;
          mem_wv_d = 1'b0;
          if (owner_q) begin
            d_ready_d = 1'b1;
            d_err_d   = ~bus.mem_ready;
            d_rdata_d = bus.mem_ready ? bus.mem_read_data : '0;
          end else begin
            if_ready_d = 1'b1;
            if_err_d   = ~bus.mem_ready;
            if_rdata_d = bus.mem_ready ? bus.mem_read_data : '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      owner_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= '0;
      mem_rv_q    <= 1'b0;
      mem_wv_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_ready_q   <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_width_q <= mem_width_d;
      mem_rv_q    <= mem_rv_d;
      mem_wv_q    <= mem_wv_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      if_err_q    <= if_err_d;
      d_ready_q   <= d_ready_d;
      d_err_q     <= d_err_d;
    end
  end

  assign bus.mem_addr        = mem_addr_q;
  assign bus.mem_write_data  = mem_wdata_q;
  assign bus.mem_width       = mem_width_q;
  assign bus.mem_read_valid  = mem_rv_q;
  assign bus.mem_write_valid = mem_wv_q;
  assign bus.if_rdata        = if_rdata_q;
  assign bus.if_ready        = if_ready_q;
  assign bus.if_err          = if_err_q;
  assign bus.d_rdata         = d_rdata_q;
  assign bus.d_ready         = d_ready_q;
  assign bus.d_err           = d_err_q;
endmodule
